// File: rtl/sys_ctrl_rx_cmd.sv
// Receive-side system controller: decodes UART RX command frames into register-file
// writes/reads and ALU operations, gating the ALU clock until the result is returned.
module sys_ctrl_rx_cmd #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] CMD_RF_WR   = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RF_RD   = 8'hBB,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RdData_Valid,
  input  logic                  ALU_OUT_VALID,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  CLK_GATE_EN,
  output logic                  CMD_ERR,
  output logic                  CMD_BUSY
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // Byte stream handshake: RX_D_VLD is a one-cycle valid with no ready; a byte is
  // consumed on the edge where it is high in a byte-consuming state, otherwise dropped.
  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT,
    ST_ALU_A, ST_ALU_B, ST_ALU_FUN, ST_ALU_WAIT
  } state_t;

  state_t                state, next_state;
  logic [CW-1:0]         tmo_cnt, tmo_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_d;
  logic                  wr_en_d, rd_en_d, alu_en_d, err_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic [FUN_WIDTH-1:0]  fun_d;
  logic                  tmo_hit;

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    next_state = state;
    wr_addr_d  = wr_addr;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    err_d      = 1'b0;
    addr_d     = RF_Address;
    wr_data_d  = RF_WrData;
    fun_d      = ALU_FUN;
    case (state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_RF_WR)        next_state = ST_WR_ADDR;
          else if (RX_P_DATA == CMD_RF_RD)   next_state = ST_RD_ADDR;
          else if (RX_P_DATA == CMD_ALU_OP)  next_state = ST_ALU_A;
          else if (RX_P_DATA == CMD_ALU_NOP) next_state = ST_ALU_FUN;
          else                               err_d      = 1'b1;
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          wr_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          next_state = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d    = 1'b1;
          addr_d     = wr_addr;
          wr_data_d  = RX_P_DATA;
          next_state = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rd_en_d    = 1'b1;
          addr_d     = RX_P_DATA[ADDR_WIDTH-1:0];
          next_state = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // A valid arriving on the timeout cycle still counts as success.
        if (RdData_Valid) next_state = ST_IDLE;
        else if (tmo_hit) begin
          err_d      = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_ALU_A: begin
        if (RX_D_VLD) begin
          wr_en_d    = 1'b1;
          addr_d     = '0;
          wr_data_d  = RX_P_DATA;
          next_state = ST_ALU_B;
        end
      end
      ST_ALU_B: begin
        if (RX_D_VLD) begin
          wr_en_d    = 1'b1;
          addr_d     = ADDR_WIDTH'(1);
          wr_data_d  = RX_P_DATA;
          next_state = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_en_d   = 1'b1;
          fun_d      = RX_P_DATA[FUN_WIDTH-1:0];
          next_state = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (ALU_OUT_VALID) next_state = ST_IDLE;
        else if (tmo_hit) begin
          err_d      = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    // Counter is zero on the first wait cycle because the previous state was not a wait.
    tmo_cnt_d = (state == ST_RD_WAIT || state == ST_ALU_WAIT) ? tmo_cnt + CW'(1) : '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      wr_addr     <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_Address  <= '0;
      RF_WrData   <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      CMD_ERR     <= 1'b0;
      CMD_BUSY    <= 1'b0;
    end else begin
      state       <= next_state;
      tmo_cnt     <= tmo_cnt_d;
      wr_addr     <= wr_addr_d;
      RF_WrEn     <= wr_en_d;
      RF_RdEn     <= rd_en_d;
      RF_Address  <= addr_d;
      RF_WrData   <= wr_data_d;
      ALU_EN      <= alu_en_d;
      ALU_FUN     <= fun_d;
      CLK_GATE_EN <= (next_state == ST_ALU_FUN) || (next_state == ST_ALU_WAIT);
      CMD_ERR     <= err_d;
      CMD_BUSY    <= (next_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sys_ctrl_rx_cmd.sv
// Directed bench for sys_ctrl_rx_cmd: frame-level stimulus with hand-computed strobes
// plus a write scoreboard fed from an expected queue.
module tb_sys_ctrl_rx_cmd;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int TIMEOUT = 255;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] RX_P_DATA = '0;
  logic          RX_D_VLD = 1'b0;
  logic          RdData_Valid = 1'b0;
  logic          ALU_OUT_VALID = 1'b0;
  logic          RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, CMD_ERR, CMD_BUSY;
  logic [AW-1:0] RF_Address;
  logic [DW-1:0] RF_WrData;
  logic [FW-1:0] ALU_FUN;

  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;
  int wr3_seen = 0;
  logic [AW+DW-1:0] exp_q[$];

  sys_ctrl_rx_cmd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData_Valid(RdData_Valid), .ALU_OUT_VALID(ALU_OUT_VALID),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .CMD_ERR(CMD_ERR), .CMD_BUSY(CMD_BUSY)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // write scoreboard: every RF_WrEn pulse must match the head of exp_q
  always @(negedge CLK) begin
    if (RST && RF_WrEn) begin
      if (RF_Address == AW'(3)) wr3_seen++;
      if (exp_q.size() == 0) check("wr_unexpected", {RF_Address, RF_WrData}, 32'hFFFF_FFFF);
      else check("wr_scoreboard", {RF_Address, RF_WrData}, exp_q.pop_front());
    end
    if (RST && RF_RdEn) rd_pulses++;
  end

  // driver tasks: start and end on a negedge
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  initial begin
    int err_early;
    repeat (2) @(negedge CLK);
    check("rst_wr_en", RF_WrEn, 0);
    check("rst_busy", CMD_BUSY, 0);
    check("rst_gate", CLK_GATE_EN, 0);
    check("rst_addr", RF_Address, 0);
    RST = 1'b1;
    tick();

    // 1: RF write AA,05,3C
    send_byte(8'hAA);
    check("t1_busy_after_op", CMD_BUSY, 1);
    send_byte(8'h05);
    check("t1_no_wr_early", RF_WrEn, 0);
    exp_q.push_back({4'h5, 8'h3C});
    send_byte(8'h3C);
    check("t1_wr_en", RF_WrEn, 1);
    check("t1_addr", RF_Address, 5);
    check("t1_data", RF_WrData, 8'h3C);
    check("t1_busy_low", CMD_BUSY, 0);
    tick();
    check("t1_wr_one_cycle", RF_WrEn, 0);
    check("t1_data_hold", RF_WrData, 8'h3C);

    // 2: RF read BB,0A then RdData_Valid 3 cycles later
    send_byte(8'hBB);
    send_byte(8'h0A);
    check("t2_rd_en", RF_RdEn, 1);
    check("t2_addr", RF_Address, 10);
    check("t2_busy_wait", CMD_BUSY, 1);
    tick();
    check("t2_rd_one_cycle", RF_RdEn, 0);
    tick();
    RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    check("t2_idle_after_valid", CMD_BUSY, 0);
    check("t2_no_err", CMD_ERR, 0);

    // 3: ALU op CC,12,34,02 then ALU_OUT_VALID after 5 cycles
    send_byte(8'hCC);
    check("t3_gate_off_a", CLK_GATE_EN, 0);
    exp_q.push_back({4'h0, 8'h12});
    send_byte(8'h12);
    check("t3_wr_a", RF_WrEn, 1);
    check("t3_gate_off_b", CLK_GATE_EN, 0);
    exp_q.push_back({4'h1, 8'h34});
    send_byte(8'h34);
    check("t3_wr_b", RF_WrEn, 1);
    check("t3_gate_on_fun", CLK_GATE_EN, 1);
    send_byte(8'h02);
    check("t3_alu_en", ALU_EN, 1);
    check("t3_alu_fun", ALU_FUN, 2);
    check("t3_no_wr", RF_WrEn, 0);
    repeat (4) begin
      tick();
      check("t3_gate_wait", CLK_GATE_EN, 1);
      check("t3_alu_en_low", ALU_EN, 0);
    end
    ALU_OUT_VALID = 1'b1;
    tick();
    ALU_OUT_VALID = 1'b0;
    check("t3_gate_drop", CLK_GATE_EN, 0);
    check("t3_busy_low", CMD_BUSY, 0);
    check("t3_no_err", CMD_ERR, 0);
    check("t3_fun_hold", ALU_FUN, 2);

    // 4: bad opcode, then DD,07 with ALU timeout
    send_byte(8'h55);
    check("t4_err_pulse", CMD_ERR, 1);
    check("t4_no_strobes", {RF_WrEn, RF_RdEn, ALU_EN}, 0);
    check("t4_stay_idle", CMD_BUSY, 0);
    tick();
    check("t4_err_one_cycle", CMD_ERR, 0);
    send_byte(8'hDD);
    check("t4_gate_on", CLK_GATE_EN, 1);
    send_byte(8'h07);
    check("t4_alu_en", ALU_EN, 1);
    check("t4_alu_fun", ALU_FUN, 7);
    err_early = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      if (i == 3) send_byte(8'hAA);  // dropped while waiting
      else tick();
      if (CMD_ERR) err_early++;
    end
    check("t4_no_early_err", err_early, 0);
    check("t4_gate_still_on", CLK_GATE_EN, 1);
    tick();
    check("t4_timeout_err", CMD_ERR, 1);
    check("t4_gate_off", CLK_GATE_EN, 0);
    check("t4_busy_off", CMD_BUSY, 0);
    tick();
    check("t4_err_cleared", CMD_ERR, 0);

    // 5: partial frame AA,03 killed by reset, then AA,04,FF
    send_byte(8'hAA);
    send_byte(8'h03);
    RST = 1'b0;
    #1;
    check("t5_busy_async_clear", CMD_BUSY, 0);
    check("t5_addr_async_clear", RF_Address, 0);
    RX_P_DATA = 8'hFF;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    check("t5_idle_after_rst", CMD_BUSY, 0);
    check("t5_no_wr_after_rst", RF_WrEn, 0);
    send_byte(8'hAA);
    send_byte(8'h04);
    exp_q.push_back({4'h4, 8'hFF});
    send_byte(8'hFF);
    check("t5_wr_en", RF_WrEn, 1);
    check("t5_addr", RF_Address, 4);
    check("t5_data", RF_WrData, 8'hFF);

    // 6: opcode-valued data bytes AA,AA,BB
    send_byte(8'hAA);
    send_byte(8'hAA);
    check("t6_no_wr_yet", RF_WrEn, 0);
    exp_q.push_back({4'hA, 8'hBB});
    send_byte(8'hBB);
    check("t6_wr_en", RF_WrEn, 1);
    check("t6_addr", RF_Address, 10);
    check("t6_data", RF_WrData, 8'hBB);
    check("t6_no_rd", RF_RdEn, 0);
    tick();
    check("t6_busy_low", CMD_BUSY, 0);

    repeat (2) tick();
    check("sb_queue_empty", exp_q.size(), 0);
    check("rd_pulse_total", rd_pulses, 1);
    check("addr3_never_written", wr3_seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
